// File: rtl/mfm_reader.sv
// -----------------------------------------------------------------------------
// mfm_reader
// Receiving end of the magnetic field meter ADC link (CNV/BUSY/SCK/SDO).
// A start request fires a CNV pulse and waits for BUSY to drop. It then clocks
// the conversion word in MSB-first and publishes it on b_field, which feeds the
// B-to-frequency calculation in the clk_200MHz domain.
//
// Build option: define MFM_PARITY_EN to read one extra odd-parity bit after
// the data bits. A word that fails the parity check is dropped and parity_err
// pulses. Without the macro exactly DATA_W bits are read and parity_err is 0.
//
// Ports:
//   clk          system clock (clk_200MHz)
//   reset        synchronous, active-high reset
//   start        conversion request, level-sampled in IDLE only
//   mfm_cnv      conversion trigger to the ADC
//   mfm_busy     ADC busy (asynchronous, 2-FF synchronised)
//   mfm_sck      serial clock to the ADC, idles low
//   mfm_sdo      serial data from the ADC
//   b_field      last good conversion word (1 LSB ~ 29.8 nT)
//   ready        one-cycle pulse when b_field updates
//   active       high whenever the reader is not idle
//   timeout_err  one-cycle pulse when BUSY never drops
//   parity_err   one-cycle pulse on a parity mismatch
// -----------------------------------------------------------------------------
module mfm_reader #(
    parameter int DATA_W       = 32,
    parameter int SCK_DIV      = 4,
    parameter int CNV_HIGH     = 4,
    parameter int BUSY_TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              mfm_cnv,
    input  logic              mfm_busy,
    output logic              mfm_sck,
    input  logic              mfm_sdo,
    output logic [DATA_W-1:0] b_field,
    output logic              ready,
    output logic              active,
    output logic              timeout_err,
    output logic              parity_err
);

`ifdef MFM_PARITY_EN
    localparam int NBITS = DATA_W + 1;
`else
    localparam int NBITS = DATA_W;
`endif
    // BUSY is ignored for this many WAIT_BUSY cycles: the synchroniser delay
    // plus the ADC's own BUSY rise latency.
    localparam int BLANK = 4;
    localparam int M0    = (BUSY_TIMEOUT > 2*SCK_DIV) ? BUSY_TIMEOUT : 2*SCK_DIV;
    localparam int M1    = (M0 > CNV_HIGH) ? M0 : CNV_HIGH;
    localparam int M2    = (M1 > BLANK + 1) ? M1 : BLANK + 1;
    localparam int CNT_W = $clog2(M2 + 1);
    localparam int BIT_W = $clog2(NBITS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CNV,
        S_WAIT_BUSY,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic [BIT_W-1:0]   bit_cnt, bit_cnt_next;
    logic [NBITS-2:0]   shreg;
    logic               busy_p0, busy_p1;
    logic               sample, last_sample, timeout_hit, sck_next;
    logic [NBITS-1:0]   word;
    logic [DATA_W-1:0]  word_data;
    logic               word_ok;

`ifdef MFM_PARITY_EN
    logic               word_ok_r;

    // Odd parity: data bits XOR parity bit must be 1.
    function automatic logic parity_ok(input logic [NBITS-1:0] w);
        return ^w;
    endfunction
`endif

    // Full word as it stands on the final sample edge: the bits collected so
    // far plus the bit currently on SDO.
    assign word      = {shreg, mfm_sdo};
    assign word_data = word[NBITS-1 -: DATA_W];
`ifdef MFM_PARITY_EN
    assign word_ok   = parity_ok(word);
`else
    assign word_ok   = 1'b1;
`endif

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        bit_cnt_next = bit_cnt;
        sample       = 1'b0;
        timeout_hit  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_CNV;
                    cnt_next   = '0;
                end
            end
            S_CNV: begin
                if (cnt == CNT_W'(CNV_HIGH - 1)) begin
                    state_next = S_WAIT_BUSY;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            S_WAIT_BUSY: begin
                if (cnt >= CNT_W'(BLANK) && !busy_p1) begin
                    state_next   = S_SHIFT;
                    cnt_next     = '0;
                    bit_cnt_next = '0;
                end else if (cnt == CNT_W'(BUSY_TIMEOUT - 1)) begin
                    state_next  = S_IDLE;
                    cnt_next    = '0;
                    timeout_hit = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            S_SHIFT: begin
                // cnt walks one bit period: SCK low for the first half, high
                // for the second; SDO is taken on the last high cycle.
                if (cnt == CNT_W'(2*SCK_DIV - 1)) begin
                    sample   = 1'b1;
                    cnt_next = '0;
                    if (bit_cnt == BIT_W'(NBITS - 1)) begin
                        state_next = S_DONE;
                    end else begin
                        bit_cnt_next = bit_cnt + BIT_W'(1);
                    end
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign last_sample = sample && (bit_cnt == BIT_W'(NBITS - 1));
    assign sck_next    = (state_next == S_SHIFT) && (cnt_next >= CNT_W'(SCK_DIV));

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            busy_p0 <= 1'b0;
            busy_p1 <= 1'b0;
            mfm_cnv <= 1'b0;
            mfm_sck <= 1'b0;
            b_field <= '0;
`ifdef MFM_PARITY_EN
            word_ok_r <= 1'b1;
`endif
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            bit_cnt <= bit_cnt_next;
            // ---- BUSY synchroniser stage 0 -> stage 1 ----
            busy_p0 <= mfm_busy;
            busy_p1 <= busy_p0;
            // CNV/SCK are registered from the next state so the ADC sees
            // glitch-free edges aligned with the state they belong to.
            mfm_cnv <= (state_next == S_CNV);
            mfm_sck <= sck_next;
            if (sample) begin
                shreg <= {shreg[NBITS-3:0], mfm_sdo};
            end
            // b_field is loaded whole on the final sample so the new word is
            // already visible in the DONE cycle that pulses ready.
            if (last_sample) begin
                if (word_ok) begin
                    b_field <= word_data;
                end
`ifdef MFM_PARITY_EN
                word_ok_r <= word_ok;
`endif
            end
        end
    end

    assign active      = (state != S_IDLE);
    assign timeout_err = timeout_hit;
`ifdef MFM_PARITY_EN
    assign ready       = (state == S_DONE) && word_ok_r;
    assign parity_err  = (state == S_DONE) && !word_ok_r;
`else
    assign ready       = (state == S_DONE);
    assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_mfm_reader.sv
// -----------------------------------------------------------------------------
// tb_mfm_reader
// Bench for mfm_reader with a behavioural ADC (BUSY for a chosen number of
// cycles after CNV rises, then SDO MSB-first, advancing on each SCK fall).
// The expected outcome, latency and b_field come from a small reference model.
// Define MFM_PARITY_EN for both bench and RTL to cover the parity build.
// -----------------------------------------------------------------------------
module tb_mfm_reader;

    localparam int DATA_W       = 32;
    localparam int SCK_DIV      = 4;
    localparam int CNV_HIGH     = 4;
    localparam int BUSY_TIMEOUT = 1024;
`ifdef MFM_PARITY_EN
    localparam int NBITS = DATA_W + 1;
`else
    localparam int NBITS = DATA_W;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              mfm_cnv;
    logic              mfm_busy;
    logic              mfm_sck;
    logic              mfm_sdo;
    logic [DATA_W-1:0] b_field;
    logic              ready;
    logic              active;
    logic              timeout_err;
    logic              parity_err;

    always #5 clk = ~clk;

    mfm_reader #(
        .DATA_W(DATA_W), .SCK_DIV(SCK_DIV), .CNV_HIGH(CNV_HIGH), .BUSY_TIMEOUT(BUSY_TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .mfm_cnv(mfm_cnv), .mfm_busy(mfm_busy),
        .mfm_sck(mfm_sck), .mfm_sdo(mfm_sdo), .b_field(b_field), .ready(ready),
        .active(active), .timeout_err(timeout_err), .parity_err(parity_err)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- ADC model ----------------
    typedef struct {
        logic [NBITS-1:0] word;
        int               busy_len;
    } adc_t;
    adc_t adc_q[$];

    initial begin
        adc_t             e;
        logic [NBITS-1:0] cur;
        int               busy_left;
        int               idx;
        logic             cnv_prev, sck_prev;
        cur = '0; busy_left = 0; idx = 0; cnv_prev = 1'b0; sck_prev = 1'b0;
        mfm_busy = 1'b0;
        mfm_sdo  = 1'b0;
        forever begin
            step();
            if (mfm_cnv && !cnv_prev) begin
                if (adc_q.size() > 0) begin
                    e = adc_q.pop_front();
                    cur = e.word;
                    busy_left = e.busy_len - 1;
                end else begin
                    cur = '0;
                    busy_left = 0;
                end
                idx = NBITS - 1;
                mfm_busy = 1'b1;
            end else if (busy_left > 0) begin
                busy_left--;
            end else if (mfm_busy) begin
                mfm_busy = 1'b0;
                mfm_sdo  = cur[idx];
            end
            if (sck_prev && !mfm_sck && idx > 0) begin
                idx--;
                mfm_sdo = cur[idx];
            end
            cnv_prev = mfm_cnv;
            sck_prev = mfm_sck;
        end
    end

    // ---------------- waveform monitor ----------------
    int   cnv_hi = 0, sck_rises = 0, sck_bad = 0, last_rise = -1, mon_cyc = 0;
    logic sck_q = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            mon_cyc++;
            if (mfm_cnv) cnv_hi++;
            if (mfm_sck && !sck_q) begin
                sck_rises++;
                if (last_rise >= 0 && (mon_cyc - last_rise) != 2*SCK_DIV) sck_bad++;
                last_rise = mon_cyc;
            end
            sck_q = mfm_sck;
        end
    end

    task automatic clear_mon();
        cnv_hi = 0; sck_rises = 0; sck_bad = 0; last_rise = -1;
    endtask

    // ---------------- reference model ----------------
    // Cycle (start cycle = 0) on which ready or parity_err is expected. The ADC
    // holds BUSY for busy_len cycles from the first CNV cycle; the reader sees
    // it low two cycles later and never before 4 cycles into WAIT_BUSY.
    function automatic int exp_latency(input int busy_len);
        int k;
        k = busy_len + 2 - CNV_HIGH;
        if (k < 4) k = 4;
        return 1 + CNV_HIGH + (k + 1) + NBITS*2*SCK_DIV;
    endfunction

    // Word on the wire for a data value, with a correct parity bit if enabled.
    function automatic logic [NBITS-1:0] mk_word(input logic [DATA_W-1:0] d);
`ifdef MFM_PARITY_EN
        return {d, ~(^d)};
`else
        return d;
`endif
    endfunction

    task automatic wait_pulse(input int budget, output int n, output bit r, output bit t, output bit p);
        n = 0; r = 0; t = 0; p = 0;
        while (!(r || t || p) && n < budget) begin
            step();
            n++;
            r = ready; t = timeout_err; p = parity_err;
        end
    endtask

    // One conversion from a start pulse. Call #1 after a rising edge.
    task automatic run_conv(input string tag, input logic [NBITS-1:0] word, input int busy_len,
                            input bit extra, input bit exp_r, input bit exp_t, input bit exp_p,
                            input logic [DATA_W-1:0] exp_b);
        int n, exp_n, act_hi;
        bit r, t, p;
        adc_q.push_back('{word, busy_len});
        clear_mon();
        start = 1'b1;
        n = 0; r = 0; t = 0; p = 0;
        while (!(r || t || p) && n < 3000) begin
            step();
            n++;
            // extra requests land in CNV (cycle 2) and mid-SHIFT (cycle 120)
            start = extra && (n == 2 || n == 120);
            r = ready; t = timeout_err; p = parity_err;
        end
        start = 1'b0;
        exp_n = exp_t ? (1 + CNV_HIGH + BUSY_TIMEOUT - 1) : exp_latency(busy_len);
        check({tag, " outcome r/t/p"}, {r, t, p}, {exp_r, exp_t, exp_p});
        check({tag, " pulse cycle"}, n, exp_n);
        check({tag, " cnv width"}, cnv_hi, CNV_HIGH);
        check({tag, " sck pulses"}, sck_rises, exp_t ? 0 : NBITS);
        check({tag, " sck period"}, sck_bad, 0);
        step();
        check({tag, " pulse width"}, {ready, timeout_err, parity_err}, 3'b000);
        check({tag, " b_field"}, b_field, exp_b);
        act_hi = 0;
        for (int i = 0; i < 3; i++) begin
            if (active) act_hi++;
            step();
        end
        check({tag, " idle after"}, act_hi, 0);
    endtask

    typedef struct {
        logic [NBITS-1:0]  word;
        int                busy_len;
        bit                extra;
        bit                exp_r;
        bit                exp_t;
        bit                exp_p;
        logic [DATA_W-1:0] exp_b;
    } vec_t;

    initial begin
        vec_t              vecs[$];
        logic [DATA_W-1:0] model_b;
        int                n;
        bit                r, t, p;

        vecs.push_back('{mk_word(32'h0000_00FF),   20, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_00FF});
        vecs.push_back('{mk_word(32'hA5A5_5A5A),    5, 1'b0, 1'b1, 1'b0, 1'b0, 32'hA5A5_5A5A});
        vecs.push_back('{mk_word(32'h8000_0001),    1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h8000_0001});
        vecs.push_back('{mk_word(32'h1234_5678), 2000, 1'b0, 1'b0, 1'b1, 1'b0, 32'h8000_0001});
        vecs.push_back('{mk_word(32'hFFFF_FFFF),    9, 1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF});
        vecs.push_back('{mk_word(32'h0000_0000),    3, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0000});
        vecs.push_back('{mk_word(32'h7FFF_FFFE),   30, 1'b1, 1'b1, 1'b0, 1'b0, 32'h7FFF_FFFE});
`ifdef MFM_PARITY_EN
        vecs.push_back('{{32'h0000_0001, 1'b0},     6, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0001});
        vecs.push_back('{{32'h0000_0001, 1'b1},     6, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0001});
`endif

        reset = 1'b1;
        start = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        step();
        check("reset outputs", {mfm_cnv, mfm_sck, ready, active, timeout_err, parity_err}, 6'b0);
        check("reset b_field", b_field, 0);

        model_b = '0;
        for (int i = 0; i < vecs.size(); i++) begin
            run_conv($sformatf("vec%0d", i), vecs[i].word, vecs[i].busy_len, vecs[i].extra,
                     vecs[i].exp_r, vecs[i].exp_t, vecs[i].exp_p, vecs[i].exp_b);
            model_b = vecs[i].exp_b;
        end

        for (int i = 0; i < 6; i++) begin
            logic [DATA_W-1:0] d;
            logic [NBITS-1:0]  w;
            int                b;
            bit                bad;
            d   = $urandom;
            b   = $urandom_range(1, 40);
            w   = mk_word(d);
            bad = 1'b0;
`ifdef MFM_PARITY_EN
            bad = 1'($urandom_range(0, 1));
            if (bad) w[0] = ~w[0];
`endif
            if (!bad) model_b = d;
            run_conv($sformatf("rnd%0d", i), w, b, i[0], !bad, 1'b0, bad, model_b);
        end

        // back-to-back conversions with start held high
        adc_q.push_back('{mk_word(32'hA5A5_5A5A), 12});
        adc_q.push_back('{mk_word(32'h8000_0001), 7});
        clear_mon();
        start = 1'b1;
        wait_pulse(3000, n, r, t, p);
        check("b2b first ready", {r, t, p}, 3'b100);
        check("b2b first cycle", n, exp_latency(12));
        step();
        check("b2b first b_field", b_field, 32'hA5A5_5A5A);
        check("b2b idle gap", active, 1'b0);
        clear_mon();
        step();
        start = 1'b0;
        check("b2b second cnv", mfm_cnv, 1'b1);
        wait_pulse(3000, n, r, t, p);
        check("b2b second ready", {r, t, p}, 3'b100);
        check("b2b second cycle", n + 1, exp_latency(7));
        check("b2b second cnv width", cnv_hi, CNV_HIGH);
        step();
        check("b2b second b_field", b_field, 32'h8000_0001);
        step();

        // reset during bit 10 of SHIFT
        adc_q.push_back('{mk_word(32'hDEAD_BEEF), 10});
        clear_mon();
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (sck_rises < 11 && n < 2000) begin
            step();
            n++;
        end
        check("reach bit 10", (sck_rises >= 11), 1'b1);
        reset = 1'b1;
        step();
        check("mid-shift reset outputs", {mfm_cnv, mfm_sck, active, ready}, 4'b0);
        check("mid-shift reset b_field", b_field, 0);
        reset = 1'b0;
        step();
        run_conv("post-reset", mk_word(32'h0F0F_F0F0), 4, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0F0F_F0F0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got hang, expected $finish");
        $fatal(1);
    end

endmodule
